// File: rtl/register_file_mp_pkg.sv
// Shared defaults and scoreboard helpers for the multi-port rv32i register file.
package register_file_mp_pkg;

  localparam int DATA_WIDTH     = 32;
  localparam int NUM_REGISTERS  = 32;
  localparam int REG_ADDR_WIDTH = $clog2(NUM_REGISTERS);

  // Per-register busy-bit action for one cycle, resolved by priority before use.
  typedef enum logic [1:0] {
    SB_HOLD  = 2'd0,
    SB_CLEAR = 2'd1,
    SB_SET   = 2'd2
  } sb_op_e;

  function automatic logic sb_next(input sb_op_e op, input logic cur);
    case (op)
      SB_SET:   return 1'b1;
      SB_CLEAR: return 1'b0;
      default:  return cur;
    endcase
  endfunction

endpackage

// File: rtl/register_file_mp_if.sv
// Decode/writeback-side bus of the register file: read ports, write ports, reserve and flush.
interface register_file_mp_if
  import register_file_mp_pkg::*;
#(
  parameter int XLEN     = DATA_WIDTH,
  parameter int NUM_REGS = NUM_REGISTERS,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2
);
  localparam int AW = $clog2(NUM_REGS);

  logic [NUM_RD-1:0]      rd_en;
  logic [NUM_RD*AW-1:0]   rd_addr;
  logic [NUM_RD*XLEN-1:0] rd_data;
  logic [NUM_RD-1:0]      rd_ready;

  logic [NUM_WR-1:0]      wr_en;
  logic [NUM_WR*AW-1:0]   wr_addr;
  logic [NUM_WR*XLEN-1:0] wr_data;

  logic                   rsv_en;
  logic [AW-1:0]          rsv_addr;
  logic                   flush;
  logic [NUM_REGS-1:0]    busy_vec;

  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, flush,
    input  rd_data, rd_ready, busy_vec
  );

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, flush,
    output rd_data, rd_ready, busy_vec
  );

endinterface

// File: rtl/register_file_mp_scoreboard.sv
// Busy-bit scoreboard: long-latency producers reserve rd, writeback clears it, flush clears all.
module register_file_mp_scoreboard
  import register_file_mp_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGISTERS,
  parameter int NUM_WR   = 2,
  parameter int AW       = $clog2(NUM_REGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rsv_en_i,
  input  logic [AW-1:0]        rsv_addr_i,
  input  logic                 flush_i,
  input  logic [NUM_WR-1:0]    wr_en_i,
  input  logic [NUM_WR*AW-1:0] wr_addr_i,
  output logic [NUM_REGS-1:0]  busy_vec_o
);

  // x0 has no busy bit at all, so it can never appear busy.
  logic [NUM_REGS-1:1] busy_q, busy_d;
  sb_op_e              op;

  // Later assignments override earlier ones: writeback < reserve < flush.
  always_comb begin
    // NOTE: every variable gets a default before any conditional update, so no latch is inferred.
    busy_d = busy_q;
    op     = SB_HOLD;
    for (int r = 1; r < NUM_REGS; r++) begin
      op = SB_HOLD;
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_en_i[w] && wr_addr_i[w*AW +: AW] == AW'(r)) op = SB_CLEAR;
      end
      if (rsv_en_i && rsv_addr_i == AW'(r)) op = SB_SET;
      if (flush_i) op = SB_CLEAR;
      busy_d[r] = sb_next(op, busy_q[r]);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign busy_vec_o = {busy_q, 1'b0};

endmodule

// File: rtl/register_file_mp.sv
// Multi-port integer register file with same-cycle write->read bypass and busy scoreboard.
module register_file_mp
  import register_file_mp_pkg::*;
#(
  parameter int XLEN     = DATA_WIDTH,
  parameter int NUM_REGS = NUM_REGISTERS,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int BYPASS   = 1
) (
  input  logic clk,
  input  logic rst,
  register_file_mp_if.slave bus
);

  localparam int AW = $clog2(NUM_REGS);

  logic [XLEN-1:0]     regs_q [1:NUM_REGS-1];
  logic [XLEN-1:0]     regs_d [1:NUM_REGS-1];
  logic [NUM_REGS-1:0] busy_vec;

  logic [AW-1:0]       rd_addr_c;
  logic [XLEN-1:0]     rd_val;
  logic                rd_busy;
  logic                rd_hit;

  // Higher-indexed write ports are younger, so they are applied last and win.
  always_comb begin
    regs_d = regs_q;
    for (int r = 1; r < NUM_REGS; r++) begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (bus.wr_en[w] && bus.wr_addr[w*AW +: AW] == AW'(r)) begin
          regs_d[r] = bus.wr_data[w*XLEN +: XLEN];
        end
      end
    end
  end

  // NOTE: the storage array is reset because consumers rely on x1..xN-1 reading 0 after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 1; r < NUM_REGS; r++) regs_q[r] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  register_file_mp_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .NUM_WR   (NUM_WR),
    .AW       (AW)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .rsv_en_i   (bus.rsv_en),
    .rsv_addr_i (bus.rsv_addr),
    .flush_i    (bus.flush),
    .wr_en_i    (bus.wr_en),
    .wr_addr_i  (bus.wr_addr),
    .busy_vec_o (busy_vec)
  );

  assign bus.busy_vec = busy_vec;

  // Read mux per port; x0 matches no stored register, so it reads 0 and is never busy.
  always_comb begin
    bus.rd_data  = '0;
    bus.rd_ready = '1;
    rd_addr_c    = '0;
    rd_val       = '0;
    rd_busy      = 1'b0;
    rd_hit       = 1'b0;
    for (int p = 0; p < NUM_RD; p++) begin
      rd_addr_c = bus.rd_addr[p*AW +: AW];
      rd_val    = '0;
      rd_busy   = 1'b0;
      rd_hit    = 1'b0;
      for (int r = 1; r < NUM_REGS; r++) begin
        if (rd_addr_c == AW'(r)) begin
          rd_val  = regs_q[r];
          rd_busy = busy_vec[r];
        end
      end
      if (BYPASS != 0) begin
        for (int w = 0; w < NUM_WR; w++) begin
          if (bus.wr_en[w] && rd_addr_c != '0 && bus.wr_addr[w*AW +: AW] == rd_addr_c) begin
            rd_val = bus.wr_data[w*XLEN +: XLEN];
            rd_hit = 1'b1;
          end
        end
      end
      if (bus.rd_en[p]) begin
        bus.rd_data[p*XLEN +: XLEN] = rd_val;
        bus.rd_ready[p]             = !rd_busy || rd_hit;
      end
    end
  end

endmodule
